// File: rtl/kvaz_multi.sv
// Multi-disk RAM-disk page mapper: per-disk control registers, stack/ram claim
// arbitration into a flat SDRAM page space, deferred register commit, sticky conflict flag.

module kvaz_disk_claim #(
    parameter int EXT_WIN = 1
) (
    input  logic [3:0] ctl_i,      // {win_ef, win_89, ram_on, stack_on}
    input  logic [3:0] hi_i,
    input  logic       stack_i,
    output logic       stack_clm_o,
    output logic       ram_clm_o
);
    logic win;

    assign win = (hi_i >= 4'hA && hi_i <= 4'hD)
               || ((EXT_WIN != 0) && ctl_i[2] && hi_i[3:1] == 3'b100)
               || ((EXT_WIN != 0) && ctl_i[3] && hi_i[3:1] == 3'b111);
    assign stack_clm_o = ctl_i[0] & stack_i;
    assign ram_clm_o   = ctl_i[1] & win;
endmodule

module kvaz_multi #(
    parameter int         NDISK     = 4,
    parameter logic [7:0] PORT_BASE = 8'h10,
    parameter int         EXT_WIN   = 1,
    parameter int         DEFER     = 1,
    parameter int         BA_W      = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clke,
    input  logic [7:0]      shavv,
    input  logic [7:0]      io_addr,
    input  logic            select,
    input  logic [7:0]      data_in,
    input  logic            stack,
    input  logic            memwr,
    input  logic            memrd,
    output logic [BA_W-1:0] bigram_addr,
    output logic            blk_n,
    output logic [7:0]      cr_rd_data,
    output logic            conflict,
    output logic [7:0]      debug
);
    typedef enum logic {IDLE, PEND} state_t;

    state_t                     state_q;
    logic [2:0]                 pidx_q;
    logic [7:0]                 pdat_q;
    logic [NDISK-1:0][7:0]      cr_q, cr_d;
    logic [BA_W-1:0]            big_q;
    logic                       blk_q, conf_q;

    logic [7:0] off;
    logic       in_rng, wr_en, busy, pend_commit, direct_commit;
    logic [2:0] wr_idx;
    logic       unused_lo;

    assign off    = io_addr - PORT_BASE;
    assign in_rng = (io_addr >= PORT_BASE) && (off < 8'(NDISK));
    assign wr_idx = off[2:0];
    assign wr_en  = clke & select & in_rng;
    assign busy   = memrd | memwr;
    assign unused_lo = ^{shavv[3:0], off[7:3]};

    // A pending value drains when the bus goes idle or when a newer write pushes it out.
    assign pend_commit   = (DEFER != 0) && (state_q == PEND) && (wr_en || !busy);
    assign direct_commit = wr_en && ((DEFER == 0) || !busy);

    always_comb begin
        cr_d = cr_q;
        for (int d = 0; d < NDISK; d++) begin
            if (pend_commit && pidx_q == 3'(d)) cr_d[d] = pdat_q;
            if (direct_commit && wr_idx == 3'(d)) cr_d[d] = data_in;
        end
    end

    always_comb begin
        cr_rd_data = 8'h00;
        for (int d = 0; d < NDISK; d++)
            if (in_rng && off == 8'(d)) cr_rd_data = cr_q[d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pidx_q  <= 3'd0;
            pdat_q  <= 8'h00;
        end else if (DEFER != 0) begin
            case (state_q)
                IDLE: if (wr_en && busy) begin
                    pidx_q  <= wr_idx;
                    pdat_q  <= data_in;
                    state_q <= PEND;
                end
                PEND: begin
                    if (wr_en && busy) begin
                        pidx_q <= wr_idx;
                        pdat_q <= data_in;
                    end else if (wr_en || !busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cr_q <= '0;
        else       cr_q <= cr_d;
    end

    logic [NDISK-1:0] stk_clm, ram_clm;

    for (genvar g = 0; g < NDISK; g++) begin : g_disk
        kvaz_disk_claim #(.EXT_WIN(EXT_WIN)) u_claim (
            .ctl_i       (cr_q[g][7:4]),
            .hi_i        (shavv[7:4]),
            .stack_i     (stack),
            .stack_clm_o (stk_clm[g]),
            .ram_clm_o   (ram_clm[g])
        );
    end

    logic            win_v;
    logic [2:0]      win_idx;
    logic [1:0]      win_pg;
    logic [3:0]      nclm;
    logic [BA_W-1:0] win_page;

    // Descending scans so the lowest index wins; stack pass runs last so it overrides ram.
    always_comb begin
        win_v   = 1'b0;
        win_idx = 3'd0;
        win_pg  = 2'd0;
        nclm    = 4'd0;
        for (int d = NDISK-1; d >= 0; d--)
            if (ram_clm[d]) begin
                win_v = 1'b1; win_idx = 3'(d); win_pg = cr_q[d][1:0];
            end
        for (int d = NDISK-1; d >= 0; d--)
            if (stk_clm[d]) begin
                win_v = 1'b1; win_idx = 3'(d); win_pg = cr_q[d][3:2];
            end
        for (int d = 0; d < NDISK; d++)
            nclm = nclm + 4'(stk_clm[d] | ram_clm[d]);
    end

    assign win_page = BA_W'({win_idx, win_pg}) + BA_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            big_q  <= '0;
            blk_q  <= 1'b1;
            conf_q <= 1'b0;
        end else if (clke) begin
            big_q <= win_v ? win_page : '0;
            blk_q <= ~win_v;
            if (nclm > 4'd1) conf_q <= 1'b1;
        end
    end

    assign bigram_addr = big_q;
    assign blk_n       = blk_q;
    assign conflict    = conf_q;
    assign debug       = {state_q == PEND, pidx_q, win_v, win_idx};
endmodule

// File: tb/tb_kvaz_multi.sv
// Bench for kvaz_multi: two instances (EXT_WIN=1 / EXT_WIN=0) against a behavioural
// model checked every cycle, plus literal expectations from the directed scenarios.

module tb_kvaz_multi;
    logic       clk = 0, reset = 0, clke = 0, select = 0, stack = 0, memwr = 0, memrd = 0;
    logic [7:0] shavv = 0, io_addr = 0, data_in = 0;
    logic [5:0] big_a, big_b;
    logic       blk_a, blk_b, conf_a, conf_b;
    logic [7:0] cr_a, cr_b, dbg_a, dbg_b;
    int total = 0, bad = 0;
    bit started = 0;

    always #5 clk = ~clk;

    kvaz_multi #(.NDISK(4), .PORT_BASE(8'h10), .EXT_WIN(1), .DEFER(1), .BA_W(6)) dut_a (
        .clk(clk), .reset(reset), .clke(clke), .shavv(shavv), .io_addr(io_addr),
        .select(select), .data_in(data_in), .stack(stack), .memwr(memwr), .memrd(memrd),
        .bigram_addr(big_a), .blk_n(blk_a), .cr_rd_data(cr_a), .conflict(conf_a), .debug(dbg_a));

    kvaz_multi #(.NDISK(4), .PORT_BASE(8'h10), .EXT_WIN(0), .DEFER(1), .BA_W(6)) dut_b (
        .clk(clk), .reset(reset), .clke(clke), .shavv(shavv), .io_addr(io_addr),
        .select(select), .data_in(data_in), .stack(stack), .memwr(memwr), .memrd(memrd),
        .bigram_addr(big_b), .blk_n(blk_b), .cr_rd_data(cr_b), .conflict(conf_b), .debug(dbg_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_reg [4];
    bit         m_pv;
    int         m_pd;
    logic [7:0] m_pdat;
    int         m_big [2];
    bit         m_blk [2], m_conf [2];

    function automatic void arb(input bit ext, output int page, output bit any, output int n);
        int ws = -1, wrm = -1;
        int hi = int'(shavv[7:4]);
        n = 0;
        for (int d = 0; d < 4; d++) begin
            bit win = (hi >= 10 && hi <= 13) || (ext && m_reg[d][6] && (hi == 8 || hi == 9))
                      || (ext && m_reg[d][7] && hi >= 14);
            bit sc = m_reg[d][4] && stack;
            bit rc = m_reg[d][5] && win;
            if (sc || rc) n++;
            if (sc && ws < 0) ws = d;
            if (rc && wrm < 0) wrm = d;
        end
        any = (ws >= 0) || (wrm >= 0);
        if (ws >= 0)       page = 1 + 4*ws + int'(m_reg[ws][3:2]);
        else if (wrm >= 0) page = 1 + 4*wrm + int'(m_reg[wrm][1:0]);
        else               page = 0;
    endfunction

    function automatic logic [7:0] cr_exp(input logic [7:0] io);
        if (io >= 8'h10 && io < 8'h14) return m_reg[io - 8'h10];
        return 8'h00;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) m_reg[d] = 8'h00;
            m_pv = 0; m_pd = 0; m_pdat = 0;
            for (int e = 0; e < 2; e++) begin m_big[e] = 0; m_blk[e] = 1; m_conf[e] = 0; end
        end else begin
            bit wr, busy, any;
            int pg, n;
            if (clke)
                for (int e = 0; e < 2; e++) begin
                    arb(e == 0, pg, any, n);
                    m_big[e] = pg; m_blk[e] = !any;
                    if (n > 1) m_conf[e] = 1;
                end
            wr   = clke && select && io_addr >= 8'h10 && io_addr < 8'h14;
            busy = memrd || memwr;
            if (wr) begin
                if (m_pv) begin m_reg[m_pd] = m_pdat; m_pv = 0; end
                if (busy) begin m_pv = 1; m_pd = int'(io_addr) - 16; m_pdat = data_in; end
                else m_reg[int'(io_addr) - 16] = data_in;
            end else if (m_pv && !busy) begin
                m_reg[m_pd] = m_pdat; m_pv = 0;
            end
        end
    end

    always @(negedge clk) if (started) begin
        int pg, n;
        bit any;
        chk("big_a", 32'(big_a), 32'(m_big[0]));
        chk("blk_a", 32'(blk_a), 32'(m_blk[0]));
        chk("conf_a", 32'(conf_a), 32'(m_conf[0]));
        chk("big_b", 32'(big_b), 32'(m_big[1]));
        chk("blk_b", 32'(blk_b), 32'(m_blk[1]));
        chk("conf_b", 32'(conf_b), 32'(m_conf[1]));
        chk("cr_a", 32'(cr_a), 32'(cr_exp(io_addr)));
        chk("cr_b", 32'(cr_b), 32'(cr_exp(io_addr)));
        chk("pend_a", 32'(dbg_a[7]), 32'(m_pv));
        if (m_pv) chk("pidx_a", 32'(dbg_a[6:4]), 32'(m_pd));
        arb(1, pg, any, n);
        chk("winv_a", 32'(dbg_a[3]), 32'(any));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] v);
        io_addr = p; data_in = v; select = 1; clke = 1;
        tick();
        select = 0;
    endtask

    task automatic peek_cr(input logic [7:0] p, input logic [7:0] exp, input string nm);
        io_addr = p; #1;
        chk(nm, 32'(cr_a), 32'(exp));
    endtask

    initial begin
        #1 reset = 1; started = 1;
        repeat (2) tick();
        chk("rst_big", 32'(big_a), 0);
        chk("rst_blk", 32'(blk_a), 1);
        chk("rst_conf", 32'(conf_a), 0);
        chk("rst_dbg", 32'(dbg_a), 0);
        reset = 0;
        tick();

        // reset while a write is pending
        memrd = 1;
        wr(8'h11, 8'h20);
        chk("pend_lit", 32'(dbg_a[7]), 1);
        peek_cr(8'h11, 8'h00, "pend_invisible");
        reset = 1; #1;
        chk("rst2_dbg", 32'(dbg_a), 0);
        chk("rst2_big", 32'(big_a), 0);
        chk("rst2_blk", 32'(blk_a), 1);
        chk("rst2_cr", 32'(cr_a), 0);
        tick();
        reset = 0; memrd = 0;
        tick();
        peek_cr(8'h11, 8'h00, "pend_discarded");

        // single disk
        wr(8'h10, 8'h21);
        shavv = 8'hA5; tick();
        chk("single_big", 32'(big_a), 2);
        chk("single_blk", 32'(blk_a), 0);
        shavv = 8'h85; tick();
        chk("nowin_big", 32'(big_a), 0);
        chk("nowin_blk", 32'(blk_a), 1);
        clke = 0; shavv = 8'hA5; tick(); tick();
        chk("hold_big", 32'(big_a), 0);
        clke = 1; tick();
        chk("resume_big", 32'(big_a), 2);

        // stack priority and conflict
        wr(8'h12, 8'h1C);
        chk("noconf_yet", 32'(conf_a), 0);
        stack = 1; shavv = 8'hB0; tick();
        chk("stk_big", 32'(big_a), 12);
        chk("stk_blk", 32'(blk_a), 0);
        chk("stk_conf", 32'(conf_a), 1);
        stack = 0; tick();
        chk("ram_big", 32'(big_a), 2);
        chk("conf_sticky", 32'(conf_a), 1);

        // deferral
        wr(8'h10, 8'h00); wr(8'h12, 8'h00);
        shavv = 8'hC0; memwr = 1;
        wr(8'h11, 8'h23);
        tick();
        chk("defer_big", 32'(big_a), 0);
        chk("defer_blk", 32'(blk_a), 1);
        peek_cr(8'h11, 8'h00, "defer_cr");
        memwr = 0; tick();
        peek_cr(8'h11, 8'h23, "commit_cr");
        tick();
        chk("commit_big", 32'(big_a), 8);

        // back-to-back while busy
        memrd = 1;
        wr(8'h13, 8'h20); wr(8'h13, 8'h21);
        peek_cr(8'h13, 8'h20, "b2b_first");
        chk("b2b_pend", 32'(dbg_a[7:4]), 32'h0B);
        memrd = 0; tick();
        peek_cr(8'h13, 8'h21, "b2b_second");
        chk("b2b_idle", 32'(dbg_a[7]), 0);

        // extended windows and out-of-range ports
        wr(8'h11, 8'h00); wr(8'h13, 8'h00); wr(8'h10, 8'hE0);
        shavv = 8'hF3; tick(); tick();
        chk("ext_big_a", 32'(big_a), 1);
        chk("ext_blk_a", 32'(blk_a), 0);
        chk("ext_big_b", 32'(big_b), 0);
        chk("ext_blk_b", 32'(blk_b), 1);
        shavv = 8'h85; tick();
        chk("w89_big_a", 32'(big_a), 1);
        chk("w89_blk_b", 32'(blk_b), 1);
        wr(8'h14, 8'hFF); wr(8'h0F, 8'hFF);
        peek_cr(8'h10, 8'hE0, "oor_keep0");
        peek_cr(8'h13, 8'h00, "oor_keep3");
        peek_cr(8'h14, 8'h00, "oor_read");
        tick();
        chk("oor_big", 32'(big_a), 1);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
